// File: rtl/lcd_cmd_arbiter.sv
// Round-robin arbiter for the shared character-LCD write port. It serializes each
// granted requester's writes and holds the port for the panel execution time after each one.
module lcd_cmd_arbiter #(
    parameter int T_SHORT = 740,
    parameter int T_CLEAR = 30400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [3:0]  wr_i,
    input  logic [3:0]  dr_i,
    input  logic [31:0] dbi_i,
    input  logic [31:0] direc_i,
    output logic [3:0]  gnt,
    output logic [3:0]  rdy,
    output logic        wr,
    output logic        dr,
    output logic [7:0]  dbi,
    output logic [7:0]  direc
);

    localparam int T_MAX = (T_CLEAR > T_SHORT) ? T_CLEAR : T_SHORT;
    localparam int CW    = $clog2(T_MAX + 1);
    localparam logic [CW-1:0] LD_SHORT = CW'(T_SHORT - 1);
    localparam logic [CW-1:0] LD_CLEAR = CW'(T_CLEAR - 1);

    typedef enum logic [1:0] {IDLE, READY, ISSUE, WAIT} state_t;

    state_t          state;
    logic [1:0]      ptr;
    logic [CW-1:0]   cnt;
    logic            is_instr;
    logic [1:0]      pick_idx;
    logic            pick_hit;

    // Search ptr+1, ptr+2, ptr+3, ptr; walking the offsets downward lets the
    // nearest set bit overwrite any farther one.
    always_comb begin
        pick_idx = ptr;
        pick_hit = 1'b0;
        for (int i = 4; i >= 1; i--) begin
            if (req[ptr + 2'(i)]) begin
                pick_idx = ptr + 2'(i);
                pick_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= 2'd3;
            cnt      <= '0;
            is_instr <= 1'b0;
            gnt      <= '0;
            rdy      <= '0;
            wr       <= 1'b0;
            dr       <= 1'b0;
            dbi      <= '0;
            direc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_hit) begin
                        gnt   <= 4'b0001 << pick_idx;
                        rdy   <= 4'b0001 << pick_idx;
                        ptr   <= pick_idx;
                        state <= READY;
                    end
                end
                READY: begin
                    // Instruction strobe takes priority; a simultaneous data strobe is dropped.
                    if (dr_i[ptr]) begin
                        direc    <= direc_i[ptr*8 +: 8];
                        dr       <= 1'b1;
                        is_instr <= 1'b1;
                        rdy      <= '0;
                        state    <= ISSUE;
                    end else if (wr_i[ptr]) begin
                        dbi      <= dbi_i[ptr*8 +: 8];
                        wr       <= 1'b1;
                        is_instr <= 1'b0;
                        rdy      <= '0;
                        state    <= ISSUE;
                    end else if (!req[ptr]) begin
                        gnt   <= '0;
                        rdy   <= '0;
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    wr  <= 1'b0;
                    dr  <= 1'b0;
                    cnt <= (is_instr && (direc == 8'h01 || direc == 8'h02)) ? LD_CLEAR : LD_SHORT;
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        if (req[ptr]) begin
                            rdy   <= gnt;
                            state <= READY;
                        end else begin
                            gnt   <= '0;
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lcd_cmd_arbiter.md
# lcd_cmd_arbiter

Shares the single character-LCD write port (wr/dr strobes, dbi data byte, direc instruction byte) among four menu/screen generators. It grants the port round-robin and serializes each requester's writes into one-cycle strobes toward the LCD driver. After every write it enforces the panel's execution time: long for clear/home, short otherwise. This replaces per-generator delay handling, so screen FSMs only issue a byte and wait for `rdy`.

## Interface
- T_SHORT, 740: cycles held after any write except clear/home (37 µs at 20 MHz); must be ≥ 1.
- T_CLEAR, 30400: cycles held after instruction 0x01 or 0x02 (1.52 ms at 20 MHz); must be ≥ 1.

- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset); deassertion synchronous to clk.
- req  in  4  requester k wants the port; held high for its whole write sequence (bus lock).
- wr_i  in  4  one-cycle data-write strobe from requester k.
- dr_i  in  4  one-cycle instruction-write strobe from requester k.
- dbi_i  in  32  data byte of requester k at [8k+7:8k].
- direc_i  in  32  instruction byte of requester k at [8k+7:8k].
- gnt  out  4  one-hot grant; all-zero when idle.
- rdy  out  4  rdy[k] = gnt[k] and the FSM is in READY; a strobe is accepted only then.
- wr  out  1  one-cycle data-write pulse to the LCD driver.
- dr  out  1  one-cycle instruction-write pulse to the LCD driver.
- dbi  out  8  data byte; registered, holds its last value.
- direc  out  8  instruction byte; registered, holds its last value.

## Operation
- Reset values: gnt=0, rdy=0, wr=0, dr=0, dbi=0, direc=0, state IDLE, pointer=3 (requester 0 wins first).
- IDLE: if any req bit is high, pick the first set bit searching from pointer+1 modulo 4. Set gnt to that bit, store it in pointer, go to READY.
- READY (granted requester g):
  - dr_i[g]: latch direc_i[g] into direc, go to ISSUE as an instruction.
  - else wr_i[g]: latch dbi_i[g] into dbi, go to ISSUE as data.
  - If both strobes are high, dr wins and that wr is dropped.
  - Else if req[g]=0: clear gnt, go to IDLE.
  - Strobes from non-granted requesters are ignored at all times.
- ISSUE: exactly one cycle with dr=1 (instruction) or wr=1 (data). Load the delay counter with T_CLEAR-1 if the write is an instruction and direc ∈ {0x01, 0x02}, otherwise T_SHORT-1. Go to WAIT.
- WAIT: decrement the counter; when it reaches 0, go to READY if req[g]=1, else clear gnt and go to IDLE. Dropping req mid-WAIT does not shorten the delay.
- gnt stays stable from grant until release; no preemption.
- Only the exit from IDLE re-arbitrates, so a requester holding req keeps the port for its entire sequence.

## Timing
- Grant latency: req rising at cycle t with the arbiter idle gives gnt and rdy high at t+1.
- Strobe sampled at cycle s (in READY): wr/dr and dbi/direc valid at s+1; WAIT spans s+2 to s+1+T; rdy high again at s+2+T (T = T_SHORT or T_CLEAR).
- Back-to-back writes by one requester are therefore T+2 cycles apart.
- Release: req low while in READY gives gnt=0 next cycle. The next grant comes one cycle after that (IDLE spends one cycle).
- rst low at any time: all outputs take reset values immediately; an in-flight delay is abandoned.
- dbi/direc change only on an accepted strobe of the matching type.

## Test plan
Bench uses T_SHORT=4, T_CLEAR=10.
- Reset: rst=0 mid-WAIT → gnt=0, wr=dr=0, dbi=direc=0 immediately; after release, req=0001 → gnt=0001 one cycle later.
- Single data write: req[1]=1, wr_i[1] with dbi_i[15:8]=0x45 at cycle s → wr pulse at s+1, dbi=0x45, rdy[1] low for s+1..s+5, high at s+6.
- Clear delay: dr_i[0] with direc_i[7:0]=0x01 → dr pulse, direc=0x01, rdy[0] returns 12 cycles after the strobe. Repeat with 0x86 → returns after 6 cycles.
- Round-robin: req=1111 held, each requester does one write then drops req → grant order 0,1,2,3. Reassert all → order restarts at 0.
- Lock and ignore: requester 2 granted; wr_i[0] and wr_i[3] pulse → no wr output, dbi unchanged. Requester 2 issues 3 writes with no intervening grant change.
- Simultaneous strobes: wr_i[0]=dr_i[0]=1 with dbi=0x61, direc=0xC5 → only dr pulses, direc=0xC5, dbi unchanged.
